// File: rtl/decode_ctrl_stage.sv
// D-stage control decoder feeding a registered D/X bundle under valid/ready,
// with load-use stall detection, flush handling and saturating event counters.
module decode_ctrl_stage #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit CSR_EN    = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_reg_wen,
  output logic             out_br_un,
  output logic             out_a_sel,
  output logic             out_b_sel,
  output logic             out_mem_wen,
  output logic             out_mem_ren,
  output logic             out_csr_wen,
  output logic             out_illegal,
  output logic [2:0]       out_imm_sel,
  output logic [3:0]       out_alu_sel,
  output logic [1:0]       out_wb_sel,
  output logic [2:0]       out_funct3,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_CSR    = 7'h73;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3,
                         IMM_J = 3'd4, IMM_Z = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_wen;
    logic            br_un;
    logic            a_sel;
    logic            b_sel;
    logic            mem_wen;
    logic            mem_ren;
    logic            csr_wen;
    logic            illegal;
    logic [2:0]      imm_sel;
    logic [3:0]      alu_sel;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
  } bundle_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] w_opcode, w_f7;
  logic [2:0] w_f3;
  bundle_t    w_dec, r_out;
  logic       w_uses_rs1, w_uses_rs2, w_hazard, w_advance;
  logic       r_valid;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];

  always_comb begin
    w_dec        = '0;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    w_dec.pc     = in_pc;
    w_dec.rd     = in_inst[11:7];
    w_dec.rs1    = in_inst[19:15];
    w_dec.rs2    = in_inst[24:20];
    w_dec.funct3 = w_f3;
    case (w_opcode)
      OPC_OP: begin
        w_dec.reg_wen = 1'b1;
        w_uses_rs1    = 1'b1;
        w_uses_rs2    = 1'b1;
        w_dec.alu_sel = alu_op(w_f3, w_f7 == 7'h20);
        w_dec.illegal = !((w_f7 == 7'h00) ||
                          (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        w_dec.reg_wen = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_I;
        w_uses_rs1    = 1'b1;
        w_dec.alu_sel = alu_op(w_f3, w_f3 == 3'b101 && w_f7 == 7'h20);
        w_dec.illegal = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                        (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
      end
      OPC_LOAD: begin
        w_dec.reg_wen = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.mem_ren = 1'b1;
        w_dec.wb_sel  = 2'd1;
        w_uses_rs1    = 1'b1;
        w_dec.illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_dec.mem_wen = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_S;
        w_uses_rs1    = 1'b1;
        w_uses_rs2    = 1'b1;
        w_dec.illegal = (w_f3 > 3'b010);
      end
      OPC_BRANCH: begin
        w_dec.a_sel   = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_B;
        w_dec.br_un   = w_f3[2] & w_f3[1];
        w_uses_rs1    = 1'b1;
        w_uses_rs2    = 1'b1;
        w_dec.illegal = (w_f3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        w_dec.reg_wen = 1'b1;
        w_dec.a_sel   = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_J;
        w_dec.wb_sel  = 2'd2;
      end
      OPC_JALR: begin
        w_dec.reg_wen = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_I;
        w_dec.wb_sel  = 2'd2;
        w_uses_rs1    = 1'b1;
        w_dec.illegal = (w_f3 != 3'b000);
      end
      OPC_LUI: begin
        w_dec.reg_wen = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_U;
        w_dec.alu_sel = ALU_PASSB;
      end
      OPC_AUIPC: begin
        w_dec.reg_wen = 1'b1;
        w_dec.a_sel   = 1'b1;
        w_dec.b_sel   = 1'b1;
        w_dec.imm_sel = IMM_U;
      end
      OPC_FENCE: ;
      OPC_CSR: begin
        // funct3[2] selects the zimm forms, which carry no rs1 dependency
        if (CSR_EN) begin
          w_dec.reg_wen = 1'b1;
          w_dec.csr_wen = 1'b1;
          w_dec.wb_sel  = 2'd3;
          w_dec.imm_sel = w_f3[2] ? IMM_Z : IMM_I;
          w_uses_rs1    = !w_f3[2];
          w_dec.illegal = (w_f3[1:0] == 2'b00);
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      default: w_dec.illegal = 1'b1;
    endcase
    if (w_dec.illegal) begin
      w_dec.reg_wen = 1'b0;
      w_dec.mem_wen = 1'b0;
      w_dec.mem_ren = 1'b0;
      w_dec.csr_wen = 1'b0;
    end
  end

  assign w_hazard = HAZARD_EN && r_valid && r_out.mem_ren && (r_out.rd != 5'd0) &&
                    ((w_uses_rs1 && w_dec.rs1 == r_out.rd) ||
                     (w_uses_rs2 && w_dec.rs2 == r_out.rd));
  assign w_advance = !r_valid || out_ready;
  assign in_ready  = flush || (w_advance && !w_hazard);

  // A bubble leaves the payload untouched; only a real accept reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= in_valid && !w_hazard;
      if (in_valid && !w_hazard) r_out <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (in_valid && w_hazard && w_advance && !flush && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_out.pc;
  assign out_rd      = r_out.rd;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_reg_wen = r_out.reg_wen;
  assign out_br_un   = r_out.br_un;
  assign out_a_sel   = r_out.a_sel;
  assign out_b_sel   = r_out.b_sel;
  assign out_mem_wen = r_out.mem_wen;
  assign out_mem_ren = r_out.mem_ren;
  assign out_csr_wen = r_out.csr_wen;
  assign out_illegal = r_out.illegal;
  assign out_imm_sel = r_out.imm_sel;
  assign out_alu_sel = r_out.alu_sel;
  assign out_wb_sel  = r_out.wb_sel;
  assign out_funct3  = r_out.funct3;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Registered, parametrised successor to the core's combinational control decoder. Decodes the D-stage instruction into the full control bundle, flags illegal encodings, and detects load-use hazards against the instruction it currently holds. Captures the result into the D/X pipeline register under a valid/ready handshake, with flush support. Sits between the fetch/IMEM output and the execute stage of riscv_core.

Parameters:
XLEN, 32, width of in_pc/out_pc
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = in_ready ignores hazards
CSR_EN, 1, 1 = OPC_CSR decoded (csrrw/csrrs/csrrc and immediate forms); 0 = OPC_CSR flagged illegal
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset
in_valid  in  1  D-stage instruction valid
in_ready  out  1  stage accepts in_inst this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  kill held and incoming instruction (taken branch/jump)
out_valid  out  1  X-stage bundle valid
out_ready  in  1  execute consumes bundle
out_pc  out  XLEN  registered PC
out_rd/out_rs1/out_rs2  out  5 each  register indices
out_reg_wen, out_br_un, out_a_sel, out_b_sel, out_mem_wen, out_mem_ren, out_csr_wen, out_illegal  out  1 each  control bits
out_imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-zimm
out_alu_sel  out  4  alu_code.vh encoding
out_wb_sel  out  2  0 ALU, 1 mem, 2 PC+4, 3 CSR
out_funct3  out  3  for branch/load/store width
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Clock: single domain, clk. Reset: rst_n is asynchronous, active-low. Reset drives out_valid=0, every out_* field=0, and both counters=0.
- Decode is combinational from in_inst and matches the base control decoder for all RV32I opcodes. Additions:
  - out_mem_ren=1 for loads.
  - wb_sel=3 for CSR instructions.
  - R-type: funct7 0x20 selects SUB/SRA only when funct3 is 000 or 101.
  - I-type: funct7 is checked only for shifts (funct3 001/101).
- Illegal when any of the following holds:
  - unknown opcode;
  - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not in {000,101};
  - shift-immediate funct7 illegal;
  - load funct3 in {011,110,111};
  - store funct3 > 010;
  - branch funct3 in {010,011};
  - JALR funct3 != 0;
  - CSR funct3 in {000,100}, or CSR_EN=0.
- Illegal instructions still pass through with out_valid=1 and out_illegal=1. All of reg_wen, mem_wen, mem_ren and csr_wen are forced to 0.
- rs1 use: R, I, load, store, branch, JALR, and register-form CSR. rs2 use: R, store, branch.
- hazard = HAZARD_EN & out_valid & out_mem_ren & (out_rd != 0) & ((uses_rs1 & rs1 == out_rd) | (uses_rs2 & rs2 == out_rd)).
- advance = !out_valid | out_ready.
- in_ready = flush | (advance & !hazard).
- Register update, priority order:
  1. flush: out_valid<=0. The incoming instruction is consumed and dropped.
  2. else if advance & in_valid & !hazard: load the decoded bundle, out_valid<=1.
  3. else if advance: out_valid<=0 (bubble; the payload may hold old values).
  4. else: hold all outputs unchanged (back-pressure).
- Latency: exactly 1 cycle from acceptance to out_valid.
- Hazard timing: the bubble inserted for a load-use hazard takes exactly one cycle. The following cycle out_valid=0, so the hazard clears and the dependent instruction is accepted.
- Counters:
  - stall_cnt increments on each cycle with in_valid & hazard & advance & !flush.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at all-ones and do not wrap.
- Simultaneous flush and hazard: flush wins; no stall is counted.
- out_ready=1 while out_valid=0 has no effect.
- Reset asserted mid-stall or mid-backpressure clears out_valid immediately, without waiting for a clock edge.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, all fields and counters 0 without a clock edge; first accept after release shows out_valid=1 one cycle later.
- Decode: add x3,x1,x2 (0x002081B3) then sub (0x402081B3) -> alu_sel ALU_ADD then ALU_SUB, reg_wen=1, wb_sel=0, out_rd=3, illegal=0; then 0x0000007F -> illegal=1 and all write enables 0.
- Load-use: lw x5,0(x1) then add x6,x5,x2 with out_ready=1 -> in_ready=0 for one cycle, one bubble on out_valid, add emitted next cycle, stall_cnt=1; the same pair with rd=x0 -> no stall.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs held bit-stable; on out_ready=1 the next instruction loads in the following cycle.
- Flush: flush=1 while holding a valid bundle and in_valid=1 -> out_valid=0 next cycle, input dropped, flush_cnt=1; flush coincident with a hazard -> stall_cnt unchanged.
- Parameters: CSR_EN=0 with csrrw (0x34029073) -> illegal=1, csr_wen=0; HAZARD_EN=0 with the load-use pair -> no bubble; CNT_W=2 with 5 flushes -> flush_cnt=3.
